// File: rtl/fft_pkg.sv
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants, twiddle-table helpers and the sequencer
//                state encoding for the FFT twiddle fetch path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int c_DEF_LOG2N   = 5;
    localparam int c_DEF_AW      = 5;
    localparam int c_DEF_DW      = 16;
    localparam int c_DEF_ROM_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } tw_state_t;

    // First ROM entry of stage s; stage s owns 2**s consecutive entries.
    function automatic int tw_base(input int s);
        return (1 << s) - 1;
    endfunction

    // Number of consecutive beats that reuse the same twiddle in stage s.
    function automatic int tw_rpt(input int s, input int log2n);
        return 1 << (log2n - 1 - s);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_tw_skid_fifo.sv
// ============================================================================
//  Module      : fft_tw_skid_fifo
//  Description : Small synchronous FIFO that absorbs ROM read latency between
//                address issue and the valid/ready twiddle output.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_tw_skid_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 37
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_din,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_dout,
    output logic      [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+1);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wp;
    logic [c_PW-1:0]  r_rp;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_CW'(DEPTH)) || w_do_pop);
    assign o_dout    = r_mem[r_rp];
    assign o_count   = r_count;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping with wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= (r_wp == c_PW'(DEPTH-1)) ? '0 : r_wp + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rp <= (r_rp == c_PW'(DEPTH-1)) ? '0 : r_rp + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_twiddle_fetch_seq.sv
// ============================================================================
//  Module      : fft_twiddle_fetch_seq
//  Description : Walks one FFT stage's twiddle sub-table, issues ROM addresses
//                under FIFO credit, and streams (re, im) beats over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_twiddle_fetch_seq
    import fft_pkg::*;
#(
    parameter int LOG2N   = c_DEF_LOG2N,
    parameter int AW      = c_DEF_AW,
    parameter int DW      = c_DEF_DW,
    parameter int ROM_LAT = c_DEF_ROM_LAT
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [2:0]         stage_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic      [AW-1:0]      rom_addr,
    input  wire logic [DW-1:0]      rom_re_data,
    input  wire logic [DW-1:0]      rom_im_data,
    output logic                    tw_valid,
    input  wire logic               tw_ready,
    output logic      [DW-1:0]      tw_re,
    output logic      [DW-1:0]      tw_im,
    output logic      [LOG2N-2:0]   tw_k,
    output logic                    tw_last
);

    localparam int c_CW         = LOG2N - 1;
    localparam int c_FIFO_DEPTH = ROM_LAT + 2;
    localparam int c_FW         = 2*DW + LOG2N;
    localparam int c_CNTW       = $clog2(c_FIFO_DEPTH + 1);
    localparam logic [c_CW-1:0] c_K_ONE = c_CW'(1);

    generate
        if ((2**LOG2N) - 1 > (2**AW)) begin : g_aw_too_narrow
            $error("twiddle ROM address width too small for LOG2N");
        end
    endgenerate

    tw_state_t         r_state;
    logic [2:0]        r_stage;
    logic [c_CW-1:0]   r_k;
    logic [c_CW-1:0]   r_rep;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [AW-1:0]     r_rom_addr;

    // Tag of the address currently on rom_addr, then ROM_LAT stages to the FIFO.
    logic              r_iss_v;
    logic [c_CW-1:0]   r_iss_k;
    logic              r_iss_last;
    logic [ROM_LAT-1:0] r_tag_v;
    logic [ROM_LAT-1:0] r_tag_last;
    logic [c_CW-1:0]   r_tag_k [ROM_LAT];

    logic              w_start_ok;
    logic              w_start_bad;
    logic [2:0]        w_cur_stage;
    logic [c_CW-1:0]   w_cur_k;
    logic [c_CW-1:0]   w_cur_rep;
    logic [c_CW-1:0]   w_rpt_m1;
    logic [c_CW-1:0]   w_kmax;
    logic              w_beat_last;
    logic              w_issue;
    logic              w_pop;
    int                w_inflight;
    logic              w_credit;
    logic [c_FW-1:0]   w_fifo_din;
    logic [c_FW-1:0]   w_fifo_dout;
    logic [c_CNTW-1:0] w_fifo_count;

    assign w_start_ok  = start && (r_state == IDLE) && (int'(stage_idx) < LOG2N);
    assign w_start_bad = start && (r_state == IDLE) && !(int'(stage_idx) < LOG2N);

    // The first address is issued on the same edge that accepts start.
    assign w_cur_stage = (r_state == IDLE) ? stage_idx : r_stage;
    assign w_cur_k     = (r_state == IDLE) ? '0 : r_k;
    assign w_cur_rep   = (r_state == IDLE) ? '0 : r_rep;
    assign w_rpt_m1    = c_CW'(tw_rpt(int'(w_cur_stage), LOG2N) - 1);
    assign w_kmax      = c_CW'(tw_base(int'(w_cur_stage)));
    assign w_beat_last = (w_cur_k == w_kmax) && (w_cur_rep == w_rpt_m1);

    // Count addresses issued but not yet written into the FIFO.
    always_comb begin
        w_inflight = int'(r_iss_v);
        for (int i = 0; i < ROM_LAT; i++) begin
            w_inflight += int'(r_tag_v[i]);
        end
    end

    // A beat leaving this cycle frees its slot, keeping one beat per cycle.
    assign w_pop    = tw_valid && tw_ready;
    assign w_credit = (int'(w_fifo_count) + w_inflight - int'(w_pop)) < c_FIFO_DEPTH;
    assign w_issue  = w_start_ok || ((r_state == FETCH) && w_credit);

    // Sequencer FSM with address/repeat counters and done/err pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_stage    <= '0;
            r_k        <= '0;
            r_rep      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_start_bad;
            if (w_issue) begin
                r_rom_addr <= AW'(tw_base(int'(w_cur_stage))) + AW'(w_cur_k);
                if (w_cur_rep == w_rpt_m1) begin
                    r_rep <= '0;
                    r_k   <= w_cur_k + c_K_ONE;
                end else begin
                    r_rep <= w_cur_rep + c_K_ONE;
                    r_k   <= w_cur_k;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_stage <= stage_idx;
                        r_busy  <= 1'b1;
                        r_state <= w_beat_last ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (w_issue && w_beat_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && w_fifo_dout[0]) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Issue-tag pipeline aligning k/last with the ROM data it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_v    <= 1'b0;
            r_iss_k    <= '0;
            r_iss_last <= 1'b0;
            r_tag_v    <= '0;
            r_tag_last <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_tag_k[i] <= '0;
            end
        end else begin
            r_iss_v       <= w_issue;
            r_iss_k       <= w_cur_k;
            r_iss_last    <= w_beat_last;
            r_tag_v[0]    <= r_iss_v;
            r_tag_k[0]    <= r_iss_k;
            r_tag_last[0] <= r_iss_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_tag_v[i]    <= r_tag_v[i-1];
                r_tag_k[i]    <= r_tag_k[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end
        end
    end

    assign w_fifo_din = {rom_re_data, rom_im_data, r_tag_k[ROM_LAT-1], r_tag_last[ROM_LAT-1]};

    fft_tw_skid_fifo #(
        .DEPTH (c_FIFO_DEPTH),
        .WIDTH (c_FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_tag_v[ROM_LAT-1]),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count)
    );

    // Beat fields read as zero whenever nothing is buffered.
    assign tw_valid = (w_fifo_count != '0);
    assign tw_re    = tw_valid ? w_fifo_dout[c_FW-1 -: DW]    : '0;
    assign tw_im    = tw_valid ? w_fifo_dout[c_FW-DW-1 -: DW] : '0;
    assign tw_k     = tw_valid ? w_fifo_dout[c_CW:1]          : '0;
    assign tw_last  = tw_valid && w_fifo_dout[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign rom_addr = r_rom_addr;

endmodule

`default_nettype wire

// File: tb/tb_fft_twiddle_fetch_seq.sv
// ============================================================================
//  Module      : tb_fft_twiddle_fetch_seq
//  Description : Self-checking bench for the twiddle fetch sequencer with a
//                synchronous ROM model and a beat-list reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_twiddle_fetch_seq;

    localparam int c_LOG2N = 5;
    localparam int c_AW    = 5;
    localparam int c_DW    = 16;
    localparam int c_HALF  = 16;
    localparam int c_NTBL  = 7;

    typedef struct {
        int stage;
        int ready_pct;
        bit stall;
        int inject_at;
        bit exp_err;
    } vec_t;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  k;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        stage_idx;
    logic              busy, done, err;
    logic [c_AW-1:0]   rom_addr;
    logic [c_DW-1:0]   rom_re_data, rom_im_data;
    logic              tw_valid, tw_ready, tw_last;
    logic [c_DW-1:0]   tw_re, tw_im;
    logic [3:0]        tw_k;

    logic [15:0] rom_re [32];
    logic [15:0] rom_im [32];
    beat_t       exp_q [$];
    vec_t        tbl [c_NTBL];
    int          n_vec, n_err;

    always #5 clk = ~clk;

    // Synchronous twiddle ROMs, one cycle from address to data.
    always @(posedge clk) begin
        rom_re_data <= rom_re[rom_addr];
        rom_im_data <= rom_im[rom_addr];
    end

    fft_twiddle_fetch_seq #(
        .LOG2N(c_LOG2N), .AW(c_AW), .DW(c_DW), .ROM_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stage_idx(stage_idx),
        .busy(busy), .done(done), .err(err), .rom_addr(rom_addr),
        .rom_re_data(rom_re_data), .rom_im_data(rom_im_data),
        .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
        .tw_k(tw_k), .tw_last(tw_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string name);
        check(name, {busy, done, err, tw_valid, tw_last, rom_addr, tw_re, tw_im, tw_k}, 64'd0);
    endtask

    // Stage s: twiddle k = 0..2**s-1, each repeated N/2**(s+1) times, from ROM entry 2**s-1+k.
    task automatic build_model(input int s);
        int idx;
        int addr;
        beat_t b;
        exp_q.delete();
        idx = 0;
        for (int k = 0; k < (1 << s); k++) begin
            for (int r = 0; r < (2 * c_HALF) / (1 << (s + 1)); r++) begin
                addr   = (1 << s) - 1 + k;
                b.re   = rom_re[addr];
                b.im   = rom_im[addr];
                b.k    = 4'(k);
                b.last = (idx == c_HALF - 1);
                exp_q.push_back(b);
                idx++;
            end
        end
    endtask

    task automatic run_stage(input vec_t v);
        int    first_valid, beats, last_c, stall_left, done_cnt;
        bit    hold, finished;
        beat_t held, cur;
        if (v.exp_err) exp_q.delete();
        else build_model(v.stage);
        @(negedge clk);
        start = 1'b1;
        stage_idx = 3'(v.stage);
        tw_ready = 1'b1;
        first_valid = -1; beats = 0; last_c = -10; stall_left = 0;
        done_cnt = 0; hold = 1'b0; finished = 1'b0; held = '0;
        for (int c = 1; c <= 600 && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == v.inject_at) begin
                start = 1'b1;
                stage_idx = 3'd3;
            end
            if (c == 1) begin
                check("busy_after_start", busy, !v.exp_err);
                check("err_after_start", err, v.exp_err);
            end
            if (c == 2) check("err_one_pulse", err, 0);
            if (stall_left > 0) begin
                tw_ready = 1'b0;
                stall_left--;
            end else if (v.stall && $urandom_range(0, 11) == 0) begin
                tw_ready = 1'b0;
                stall_left = 9;
            end else begin
                tw_ready = ($urandom_range(0, 99) < v.ready_pct);
            end
            cur = {tw_re, tw_im, tw_k, tw_last};
            if (hold) check("stall_stable", {tw_valid, cur}, {1'b1, held});
            hold = tw_valid && !tw_ready;
            held = cur;
            if (tw_valid && first_valid < 0) begin
                first_valid = c;
                check("first_valid_cycle", c, 3);
            end
            check("fifo_count_bound", dut.u_fifo.o_count <= 3, 1);
            if (done) done_cnt++;
            if (c == last_c + 1) begin
                check("done_after_last", done, 1);
                check("busy_clear_at_done", busy, 0);
                finished = 1'b1;
            end
            if (tw_valid && tw_ready) begin
                beats++;
                if (exp_q.size() == 0) check("beat_count_overflow", beats, c_HALF);
                else check($sformatf("stage%0d_beat%0d", v.stage, beats), cur, exp_q.pop_front());
                if (beats == c_HALF) last_c = c;
            end
            if (v.exp_err) begin
                check("err_no_valid", tw_valid, 0);
                check("err_no_busy", busy, 0);
                if (c == 5) finished = 1'b1;
            end
        end
        if (!finished) check($sformatf("stage%0d_timeout", v.stage), 0, 1);
        if (!v.exp_err) check($sformatf("stage%0d_beats_total", v.stage), beats, c_HALF);
        check($sformatf("stage%0d_done_pulses", v.stage), done_cnt, v.exp_err ? 0 : 1);
        tw_ready = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        vec_t rv;
        int   beats_m;
        bit   hit;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) begin
            rom_re[i] = 16'($urandom);
            rom_im[i] = 16'($urandom);
        end
        rst = 1'b1; start = 1'b0; stage_idx = 3'd0; tw_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        rst = 1'b0;

        tbl[0] = '{0, 100, 1'b0, 0, 1'b0};
        tbl[1] = '{2, 100, 1'b0, 0, 1'b0};
        tbl[2] = '{4, 100, 1'b0, 0, 1'b0};
        tbl[3] = '{3,  50, 1'b1, 0, 1'b0};
        tbl[4] = '{5, 100, 1'b0, 0, 1'b1};
        tbl[5] = '{1, 100, 1'b0, 6, 1'b0};
        tbl[6] = '{7, 100, 1'b0, 0, 1'b1};
        for (int i = 0; i < c_NTBL; i++) run_stage(tbl[i]);

        // Reset in the middle of stage 4, after the seventh beat is presented.
        @(negedge clk);
        start = 1'b1; stage_idx = 3'd4; tw_ready = 1'b1;
        beats_m = 0; hit = 1'b0;
        for (int c = 1; c <= 60 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (tw_valid && tw_ready) beats_m++;
            if (beats_m == 7) begin
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        check("reset_reached_beat7", hit, 1);
        @(negedge clk);
        check_reset_values("reset_mid_stage");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_reset", {done, busy, tw_valid}, 0);
        end
        rv = '{1, 100, 1'b0, 0, 1'b0};
        run_stage(rv);

        // Randomized stages and handshake patterns.
        repeat (4) begin
            rv.stage     = $urandom_range(0, 4);
            rv.ready_pct = $urandom_range(30, 100);
            rv.stall     = 1'($urandom_range(0, 1));
            rv.inject_at = $urandom_range(0, 8);
            rv.exp_err   = 1'b0;
            run_stage(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
